conv_window_scheduler: RTL and testbench
========================================

# conv_window_scheduler

Sequencing controller for the shared 3x3 convolution engine. On a start pulse it walks every valid 3x3 window of an IMG_H x IMG_W single-channel feature map, once per kernel. For each window it issues a one-cycle start to the engine, waits for the engine's done, then emits a result-write strobe with the flat output address. It sits between the layer-level control and the 3x3 engine/result buffer, and replaces ad-hoc row/column counting.

## Interface
- IMG_W, 8, input map width
- IMG_H, 8, input map height
- K, 3, kernel size (square)
- N_KER, 3, number of kernels / output channels
- Derived (localparam): OUT_W = IMG_W-K+1 (6), OUT_H = IMG_H-K+1 (6), RW = clog2(OUT_H), CW = clog2(OUT_W), KW = clog2(N_KER), AW = clog2(N_KER*OUT_H*OUT_W) (7)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  cancel pass; return to IDLE, no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result write
- eng_start  out  1  one-cycle pulse; engine latches window/kernel indices
- eng_done  in  1  engine result valid (one-cycle pulse)
- win_row  out  RW  output row (= top-left input row) of current window
- win_col  out  CW  output column of current window
- ker_idx  out  KW  current kernel
- wr_en  out  1  result-buffer write strobe
- wr_addr  out  AW  ker_idx*OUT_H*OUT_W + win_row*OUT_W + win_col

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, FINISH.
- IDLE: start=1 -> ISSUE; counters cleared to 0.
- ISSUE: eng_start=1 for exactly this cycle -> WAIT.
- WAIT: hold until eng_done=1 -> WRITE.
- WRITE: wr_en=1 and wr_addr valid this cycle. Advance counters: col fastest, then row, then kernel. If the last window was written (row=OUT_H-1, col=OUT_W-1, ker=N_KER-1) -> FINISH, else -> ISSUE.
- FINISH: done=1 -> IDLE.
- win_row/win_col/ker_idx are registered. They are stable from ISSUE through WRITE of the same window and update on the WRITE->ISSUE edge.
- Counter wrap: col OUT_W-1 -> 0 with row+1; row OUT_H-1 -> 0 with ker+1; ker does not wrap (pass ends).
- start while busy: ignored. eng_done outside WAIT: ignored. This includes eng_done in the ISSUE cycle, which is a protocol violation and must be flagged by a bench assertion.
- abort (any state): next state IDLE, counters cleared, no wr_en, no done. abort has priority over eng_done and over the start in the same cycle.
- start and abort together in IDLE: stay IDLE.

## Timing
- Reset values: busy=0, done=0, eng_start=0, wr_en=0, win_row=0, win_col=0, ker_idx=0, wr_addr=0; state IDLE.
- start sampled at cycle 0 -> eng_start at cycle 1.
- Engine latency L: eng_done L cycles after eng_start, with L≥1. Per-window period is L+2 cycles.
- Pass length: start sampled -> done = 1 + N_KER*OUT_H*OUT_W*(L+2) cycles.
- busy rises the cycle after start is sampled and falls the cycle after done.
- All outputs are registered (Moore); no combinational path from eng_done to any output.

## Structure
- Shared package conv_pkg holds:
  - the state enum
  - IMG/K/N_KER defaults
  - OUT_W/OUT_H/AW derivation functions, used by the engine and the result buffer.
- Single module. A small sub-module, win_counter (3-level nested wrap counter with last flag), is natural and reusable by the result-readout path.

## Test plan
- Default params, fixed L=9, start once -> 108 eng_start pulses and 108 wr_en pulses; wr_addr sequence 0..107 in order; done at cycle 1189; busy low at 1190.
- Random L in 1..20 per window -> same address order; wr_addr always equals ker*36+row*6+col at wr_en; exactly one done.
- start re-pulsed during the pass, and eng_done injected in ISSUE/IDLE -> no effect on sequence or count; assertion fires on the ISSUE-cycle eng_done.
- abort asserted during WAIT of window 40 -> IDLE next cycle; no further wr_en; no done. A new start restarts at addr 0.
- rst asserted mid-pass (asynchronous, between edges) -> all outputs at reset values immediately; clean full pass after release.
- IMG_W=5, IMG_H=4, N_KER=2 -> OUT 3x2, 12 writes, last wr_addr 11, done at 1+12*(L+2).

Source files
------------

// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and geometry helpers for the 3x3 convolution window scheduler,
// engine and result buffer.
package conv_window_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    FINISH
  } state_t;

  localparam int unsigned DEF_IMG_W = 8;
  localparam int unsigned DEF_IMG_H = 8;
  localparam int unsigned DEF_K     = 3;
  localparam int unsigned DEF_N_KER = 3;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned n_ker, input int unsigned oh,
                                         input int unsigned ow);
    return idx_w(n_ker * oh * ow);
  endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Control/engine/result-buffer signal bundle of the convolution window scheduler.
interface conv_window_scheduler_if #(
  parameter int unsigned RW = 3,
  parameter int unsigned CW = 3,
  parameter int unsigned KW = 2,
  parameter int unsigned AW = 7
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          eng_start;
  logic          eng_done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [KW-1:0] ker_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  modport master (
    output start, abort, eng_done,
    input  busy, done, eng_start, win_row, win_col, ker_idx, wr_en, wr_addr
  );

  modport slave (
    input  start, abort, eng_done,
    output busy, done, eng_start, win_row, win_col, ker_idx, wr_en, wr_addr
  );
endinterface

// File: rtl/conv_window_scheduler_win_counter.sv
// Three-level nested wrap counter (col fastest, then row, then kernel) with a
// last-position flag; advancing at the last position is ignored.
module conv_window_scheduler_win_counter
  import conv_window_scheduler_pkg::*;
#(
  parameter int unsigned N_ROW = 6,
  parameter int unsigned N_COL = 6,
  parameter int unsigned N_K   = 3,
  localparam int unsigned RW = idx_w(N_ROW),
  localparam int unsigned CW = idx_w(N_COL),
  localparam int unsigned KW = idx_w(N_K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [KW-1:0] o_ker,
  output logic          o_last
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [KW-1:0] r_ker;
  logic          w_col_max;
  logic          w_row_max;
  logic          w_ker_max;

  assign w_col_max = (r_col == CW'(N_COL - 1));
  assign w_row_max = (r_row == RW'(N_ROW - 1));
  assign w_ker_max = (r_ker == KW'(N_K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_ker <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_ker <= '0;
    end else if (i_adv && !o_last) begin
      if (w_col_max) begin
        r_col <= '0;
        if (w_row_max) begin
          r_row <= '0;
          r_ker <= r_ker + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_ker  = r_ker;
  assign o_last = w_col_max && w_row_max && w_ker_max;

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks every valid KxK window once per kernel: issue engine start, wait for
// engine done, then strobe the flat result address.
module conv_window_scheduler
  import conv_window_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned N_KER = DEF_N_KER
) (
  input logic                   clk,
  input logic                   rst,
  conv_window_scheduler_if.slave bus
);

  localparam int unsigned OUT_W = out_dim(IMG_W, K);
  localparam int unsigned OUT_H = out_dim(IMG_H, K);
  localparam int unsigned RW    = idx_w(OUT_H);
  localparam int unsigned CW    = idx_w(OUT_W);
  localparam int unsigned KW    = idx_w(N_KER);
  localparam int unsigned AW    = addr_w(N_KER, OUT_H, OUT_W);
  localparam int unsigned PLANE = OUT_H * OUT_W;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_eng_start;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [KW-1:0] w_ker;
  logic          w_last;
  logic          w_clr;
  logic          w_adv;
  logic [AW-1:0] w_addr;

  // Counters sit at zero while idle so a new pass always begins at window 0.
  assign w_clr  = bus.abort || (r_state == IDLE);
  assign w_adv  = (r_state == WRITE) && !bus.abort;
  assign w_addr = AW'(w_ker * PLANE + w_row * OUT_W + w_col);

  conv_window_scheduler_win_counter #(
    .N_ROW (OUT_H),
    .N_COL (OUT_W),
    .N_K   (N_KER)
  ) u_win_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_adv  (w_adv),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_ker  (w_ker),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_eng_start <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
    end else if (bus.abort) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_eng_start <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= ISSUE;
            r_busy      <= 1'b1;
            r_eng_start <= 1'b1;
          end
        end
        ISSUE: begin
          r_eng_start <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (bus.eng_done) begin
            r_state   <= WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
          end
        end
        WRITE: begin
          r_wr_en <= 1'b0;
          if (w_last) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state     <= ISSUE;
            r_eng_start <= 1'b1;
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.eng_start = r_eng_start;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.win_row   = w_row;
  assign bus.win_col   = w_col;
  assign bus.ker_idx   = w_ker;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: default 8x8/3-kernel instance and a
// 5x4/2-kernel instance, each driven by a small latency-programmable engine model.
module tb_conv_window_scheduler;
  import conv_window_scheduler_pkg::*;

  localparam int unsigned A_OW = out_dim(8, 3);
  localparam int unsigned A_OH = out_dim(8, 3);
  localparam int unsigned B_OW = out_dim(5, 3);
  localparam int unsigned B_OH = out_dim(4, 3);

  logic clk;
  logic rst;

  conv_window_scheduler_if #(
    .RW(idx_w(A_OH)), .CW(idx_w(A_OW)), .KW(idx_w(3)), .AW(addr_w(3, A_OH, A_OW))
  ) bus1 ();
  conv_window_scheduler_if #(
    .RW(idx_w(B_OH)), .CW(idx_w(B_OW)), .KW(idx_w(2)), .AW(addr_w(2, B_OH, B_OW))
  ) bus2 ();

  conv_window_scheduler #(.IMG_W(8), .IMG_H(8), .K(3), .N_KER(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  conv_window_scheduler #(.IMG_W(5), .IMG_H(4), .K(3), .N_KER(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  logic        start_v[2];
  logic        abort_v[2];
  logic        inj[2];
  logic        model_done[2];
  logic        w_es[2];
  logic        w_wr[2];
  logic        w_done[2];
  logic        w_busy[2];
  logic [31:0] w_addr[2];
  logic [31:0] w_row[2];
  logic [31:0] w_col[2];
  logic [31:0] w_ker[2];

  assign bus1.start    = start_v[0];
  assign bus1.abort    = abort_v[0];
  assign bus1.eng_done = model_done[0] | inj[0];
  assign bus2.start    = start_v[1];
  assign bus2.abort    = abort_v[1];
  assign bus2.eng_done = model_done[1] | inj[1];

  assign w_es[0]   = bus1.eng_start;
  assign w_wr[0]   = bus1.wr_en;
  assign w_done[0] = bus1.done;
  assign w_busy[0] = bus1.busy;
  assign w_addr[0] = 32'(bus1.wr_addr);
  assign w_row[0]  = 32'(bus1.win_row);
  assign w_col[0]  = 32'(bus1.win_col);
  assign w_ker[0]  = 32'(bus1.ker_idx);
  assign w_es[1]   = bus2.eng_start;
  assign w_wr[1]   = bus2.wr_en;
  assign w_done[1] = bus2.done;
  assign w_busy[1] = bus2.busy;
  assign w_addr[1] = 32'(bus2.wr_addr);
  assign w_row[1]  = 32'(bus2.win_row);
  assign w_col[1]  = 32'(bus2.win_col);
  assign w_ker[1]  = 32'(bus2.ker_idx);

  int mon_idx[2];
  int mon_es[2];
  int mon_done[2];
  int proto[2];
  int cnt[2];
  int lat_fix[2];
  int last_addr[2];
  bit lat_rnd[2];

  int n_tests = 0;
  int n_fail  = 0;
  int res_done;
  int res_busy_after;
  int res_busy_abort;

  typedef struct {
    int sel;
    int lat;
    int exp_done;
    int exp_writes;
    int exp_last;
  } vec_t;
  vec_t vecs[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: protocol check on the cycle just driven, advance to the falling
  // edge, monitor writes against the expected raster order, then step the engine model.
  task automatic tick();
    int ow;
    int oh;
    for (int s = 0; s < 2; s++)
      if (w_es[s] && (model_done[s] | inj[s])) proto[s]++;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if (w_es[s]) mon_es[s]++;
      if (w_done[s]) mon_done[s]++;
      if (w_wr[s]) begin
        ow = (s == 0) ? A_OW : B_OW;
        oh = (s == 0) ? A_OH : B_OH;
        chk($sformatf("wr_addr[%0d]", s), w_addr[s], 32'(mon_idx[s]));
        chk($sformatf("win_pos[%0d]", s), w_ker[s] * 10000 + w_row[s] * 100 + w_col[s],
            32'((mon_idx[s] / (ow * oh)) * 10000 + ((mon_idx[s] / ow) % oh) * 100
                + mon_idx[s] % ow));
        last_addr[s] = int'(w_addr[s]);
        mon_idx[s]++;
      end
      model_done[s] = 1'b0;
      if (cnt[s] != 0) begin
        cnt[s]--;
        if (cnt[s] == 0) model_done[s] = 1'b1;
      end
      if (w_es[s]) cnt[s] = lat_rnd[s] ? int'($urandom_range(1, 20)) : lat_fix[s];
    end
  endtask

  task automatic mon_clear(input int s);
    mon_idx[s] = 0; mon_es[s] = 0; mon_done[s] = 0; proto[s] = 0;
    cnt[s] = 0; model_done[s] = 1'b0; last_addr[s] = -1;
  endtask

  task automatic chk_outs0(input string nm);
    chk(nm, 32'({bus1.busy, bus1.done, bus1.eng_start, bus1.wr_en, bus1.win_row,
                 bus1.win_col, bus1.ker_idx, bus1.wr_addr}), 32'd0);
  endtask

  task automatic run_pass(input int s, input int lat, input bit rnd, input bit repulse,
                          input bit inject, input int abort_cyc, input int budget);
    mon_clear(s);
    lat_fix[s] = lat;
    lat_rnd[s] = rnd;
    res_done = -1; res_busy_after = -1; res_busy_abort = -1;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (w_done[s] && res_done < 0) res_done = cyc;
      if (res_done >= 0 && cyc == res_done + 1) begin
        res_busy_after = int'(w_busy[s]);
        break;
      end
      if (abort_cyc != 0 && cyc == abort_cyc + 1) res_busy_abort = int'(w_busy[s]);
      if (abort_cyc != 0 && cyc == abort_cyc + 30) break;
      start_v[s] = repulse && (cyc == 50 || cyc == 200);
      inj[s]     = inject && (cyc == 51);
      abort_v[s] = (abort_cyc != 0) && (cyc == abort_cyc);
      tick();
    end
    start_v[s] = 1'b0; inj[s] = 1'b0; abort_v[s] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 9, 1189, 108, 107};
    vecs[1] = '{0, 1,  325, 108, 107};
    vecs[2] = '{1, 2,   49,  12,  11};
    vecs[3] = '{1, 5,   85,  12,  11};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0; abort_v[s] = 1'b0; inj[s] = 1'b0;
      lat_fix[s] = 1; lat_rnd[s] = 1'b0;
      mon_clear(s);
    end
    repeat (2) @(negedge clk);
    chk_outs0("reset_outputs");
    rst = 1'b0;
    tick();

    // start and abort together while idle: stays idle
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("idle_start_abort_busy", 32'(w_busy[0]), 32'd0);
    tick();
    chk("idle_start_abort_es", 32'(w_es[0]), 32'd0);

    // stray engine done while idle
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    tick();
    chk("idle_engdone_outs", 32'({w_busy[0], w_wr[0], w_done[0]}), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_pass(vecs[v].sel, vecs[v].lat, 1'b0, 1'b0, 1'b0, 0, 3000);
      chk($sformatf("vec%0d_done_cycle", v), 32'(res_done), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_busy_after", v), 32'(res_busy_after), 32'd0);
      chk($sformatf("vec%0d_writes", v), 32'(mon_idx[vecs[v].sel]), 32'(vecs[v].exp_writes));
      chk($sformatf("vec%0d_eng_starts", v), 32'(mon_es[vecs[v].sel]), 32'(vecs[v].exp_writes));
      chk($sformatf("vec%0d_done_count", v), 32'(mon_done[vecs[v].sel]), 32'd1);
      chk($sformatf("vec%0d_last_addr", v), 32'(last_addr[vecs[v].sel]), 32'(vecs[v].exp_last));
      chk($sformatf("vec%0d_protocol", v), 32'(proto[vecs[v].sel]), 32'd0);
    end

    // start re-pulsed mid-pass and engine done injected during an ISSUE cycle
    run_pass(0, 3, 1'b0, 1'b1, 1'b1, 0, 3000);
    chk("noise_done_cycle", 32'(res_done), 32'd541);
    chk("noise_writes", 32'(mon_idx[0]), 32'd108);
    chk("noise_eng_starts", 32'(mon_es[0]), 32'd108);
    chk("noise_done_count", 32'(mon_done[0]), 32'd1);
    chk("noise_issue_engdone_flag", 32'(proto[0]), 32'd1);

    // abort in WAIT of window 40 (eng_start at cycle 201, WAIT 202..204)
    run_pass(0, 3, 1'b0, 1'b0, 1'b0, 203, 3000);
    chk("abort_busy_next", 32'(res_busy_abort), 32'd0);
    chk("abort_writes", 32'(mon_idx[0]), 32'd40);
    chk("abort_eng_starts", 32'(mon_es[0]), 32'd41);
    chk("abort_done_count", 32'(mon_done[0]), 32'd0);
    run_pass(0, 1, 1'b0, 1'b0, 1'b0, 0, 3000);
    chk("restart_done_cycle", 32'(res_done), 32'd325);
    chk("restart_writes", 32'(mon_idx[0]), 32'd108);

    // random engine latency per window
    run_pass(0, 1, 1'b1, 1'b0, 1'b0, 0, 3000);
    chk("rnd_done_seen", 32'(res_done > 0), 32'd1);
    chk("rnd_writes", 32'(mon_idx[0]), 32'd108);
    chk("rnd_done_count", 32'(mon_done[0]), 32'd1);
    chk("rnd_last_addr", 32'(last_addr[0]), 32'd107);

    // asynchronous reset between edges mid-pass
    mon_clear(0);
    lat_fix[0] = 1; lat_rnd[0] = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (100) tick();
    chk("rst_mid_progress", 32'(mon_idx[0] > 0), 32'd1);
    #2 rst = 1'b1;
    #1 chk_outs0("rst_mid_outputs");
    tick();
    chk_outs0("rst_held_outputs");
    rst = 1'b0;
    tick();
    run_pass(0, 1, 1'b0, 1'b0, 1'b0, 0, 3000);
    chk("post_rst_done_cycle", 32'(res_done), 32'd325);
    chk("post_rst_writes", 32'(mon_idx[0]), 32'd108);
    chk("post_rst_done_count", 32'(mon_done[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
